// File: rtl/timer_pkg.sv
// Shared definitions for the pulse capture timer: FSM states, edge-select codes
// and default widths.
package timer_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_PRE_W = 16;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_MEASURE
  } state_e;

endpackage

// File: rtl/edge_sync_detect.sv
// Two-flop synchronizer plus previous-value register; emits a one-cycle pulse on
// the edge kinds chosen by edge_sel.
module edge_sync_detect
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  input  logic [1:0] edge_sel,
  output logic       edge_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;
  logic rise_en, fall_en;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    s1_d    = sig_in;
    s2_d    = s1_q;
    prev_d  = s2_q;
    rise_en = 1'b0;
    fall_en = 1'b0;
    case (edge_sel)
      EDGE_NONE: ;
      EDGE_RISE: rise_en = 1'b1;
      EDGE_FALL: fall_en = 1'b1;
      EDGE_BOTH: begin
        rise_en = 1'b1;
        fall_en = 1'b1;
      end
    endcase
    edge_pulse = (rise_en && s2_q && !prev_q) || (fall_en && !s2_q && prev_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/pulse_capture_timer.sv
// Input-capture timer: measures prescaled ticks between selected edges and hands
// each result out through a one-entry valid/ready register with sticky flags.
module pulse_capture_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  input  logic [1:0]       edge_sel,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] cap_value,
  output logic             cap_ovf,
  output logic             cap_valid,
  input  logic             cap_ready,
  output logic             ovf_flag,
  output logic             miss_flag,
  input  logic             clr_flags
);

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic               sat_pend_q, sat_pend_d;
  logic [WIDTH-1:0]   cap_value_q, cap_value_d;
  logic               cap_ovf_q, cap_ovf_d;
  logic               cap_valid_q, cap_valid_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic               miss_flag_q, miss_flag_d;

  logic               edge_pulse;
  logic               tick, cnt_max, sat_now, capture, accept, new_ovf;
  logic [WIDTH-1:0]   cnt_nxt;

  edge_sync_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .edge_sel   (edge_sel),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    cnt_d       = cnt_q;
    sat_pend_d  = sat_pend_q;
    cap_value_d = cap_value_q;
    cap_ovf_d   = cap_ovf_q;
    cap_valid_d = cap_valid_q;
    ovf_flag_d  = ovf_flag_q;
    miss_flag_d = miss_flag_q;
    capture     = 1'b0;

    tick    = (pre_cnt_q == prescale);
    cnt_max = (cnt_q == {WIDTH{1'b1}});
    sat_now = tick && cnt_max;
    cnt_nxt = (tick && !cnt_max) ? cnt_q + WIDTH'(1) : cnt_q;
    new_ovf = sat_pend_q || sat_now;
    accept  = cap_valid_q && cap_ready;

    case (state_q)
      ST_IDLE: begin
        pre_cnt_d  = '0;
        cnt_d      = '0;
        sat_pend_d = 1'b0;
        if (en) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        pre_cnt_d  = '0;
        cnt_d      = '0;
        sat_pend_d = 1'b0;
        if (!en)             state_d = ST_IDLE;
        else if (edge_pulse) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!en) begin
          state_d    = ST_IDLE;
          pre_cnt_d  = '0;
          cnt_d      = '0;
          sat_pend_d = 1'b0;
        end else if (edge_pulse) begin
          capture    = 1'b1;
          pre_cnt_d  = '0;
          cnt_d      = '0;
          sat_pend_d = 1'b0;
        end else begin
          cnt_d      = cnt_nxt;
          sat_pend_d = new_ovf;
          pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear first so a same-cycle set overrides it.
    if (clr_flags) begin
      ovf_flag_d  = 1'b0;
      miss_flag_d = 1'b0;
    end

    if (accept) cap_valid_d = 1'b0;

    if (capture) begin
      if (new_ovf) ovf_flag_d = 1'b1;
      if (!cap_valid_q || accept) begin
        cap_value_d = cnt_nxt;
        cap_ovf_d   = new_ovf;
        cap_valid_d = 1'b1;
      end else begin
        miss_flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pre_cnt_q   <= '0;
      cnt_q       <= '0;
      sat_pend_q  <= 1'b0;
      cap_value_q <= '0;
      cap_ovf_q   <= 1'b0;
      cap_valid_q <= 1'b0;
      ovf_flag_q  <= 1'b0;
      miss_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      cnt_q       <= cnt_d;
      sat_pend_q  <= sat_pend_d;
      cap_value_q <= cap_value_d;
      cap_ovf_q   <= cap_ovf_d;
      cap_valid_q <= cap_valid_d;
      ovf_flag_q  <= ovf_flag_d;
      miss_flag_q <= miss_flag_d;
    end
  end

  assign cap_value = cap_value_q;
  assign cap_ovf   = cap_ovf_q;
  assign cap_valid = cap_valid_q;
  assign ovf_flag  = ovf_flag_q;
  assign miss_flag = miss_flag_q;

endmodule

// File: tb/tb_pulse_capture_timer.sv
// Directed bench for pulse_capture_timer (WIDTH=8 so saturation is reachable);
// inputs change and outputs are sampled on the falling clock edge.
module tb_pulse_capture_timer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sig_in;
  logic [1:0]  edge_sel;
  logic [15:0] prescale;
  logic [7:0]  cap_value;
  logic        cap_ovf;
  logic        cap_valid;
  logic        cap_ready;
  logic        ovf_flag;
  logic        miss_flag;
  logic        clr_flags;

  int n_assert = 0;
  int n_fail   = 0;

  pulse_capture_timer #(.WIDTH(8), .PRE_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .edge_sel  (edge_sel),
    .prescale  (prescale),
    .cap_value (cap_value),
    .cap_ovf   (cap_ovf),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .ovf_flag  (ovf_flag),
    .miss_flag (miss_flag),
    .clr_flags (clr_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rise_then(input int n);
    sig_in = 1'b1;
    cyc(n);
  endtask

  task automatic fall_then(input int n);
    sig_in = 1'b0;
    cyc(n);
  endtask

  task automatic rearm;
    en = 1'b0;
    cyc(2);
    en = 1'b1;
    cyc(2);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = 1'b0; edge_sel = 2'b00;
    prescale = 16'd0; cap_ready = 1'b0; clr_flags = 1'b0;
    cyc(2);
    check("reset_value", 16'(cap_value), 16'd0);
    check("reset_ovf",   16'(cap_ovf),   16'd0);
    check("reset_valid", 16'(cap_valid), 16'd0);
    check("reset_oflag", 16'(ovf_flag),  16'd0);
    check("reset_mflag", 16'(miss_flag), 16'd0);
    rst = 1'b0;

    // 1: prescale 0, rising edges 10 clk apart
    en = 1'b1; edge_sel = 2'b01; cap_ready = 1'b1;
    cyc(2);
    rise_then(3);
    check("t1_arm_only", 16'(cap_valid), 16'd0);
    cyc(2); fall_then(5);
    rise_then(3);
    check("t1_valid1", 16'(cap_valid), 16'd1);
    check("t1_value1", 16'(cap_value), 16'd10);
    check("t1_ovf1",   16'(cap_ovf),   16'd0);
    cyc(1);
    check("t1_accepted", 16'(cap_valid), 16'd0);
    cyc(1); fall_then(5);
    rise_then(3);
    check("t1_valid2", 16'(cap_valid), 16'd1);
    check("t1_value2", 16'(cap_value), 16'd10);
    cyc(2); fall_then(5);

    // 2: prescale 3, both edges, toggle every 20 clk
    prescale = 16'd3; edge_sel = 2'b11;
    rearm();
    rise_then(3);
    check("t2_arm_only", 16'(cap_valid), 16'd0);
    cyc(17);
    fall_then(3);
    check("t2_value_fall", 16'(cap_value), 16'd5);
    check("t2_valid_fall", 16'(cap_valid), 16'd1);
    cyc(17);
    rise_then(3);
    check("t2_value_rise", 16'(cap_value), 16'd5);
    cyc(17);
    fall_then(3);
    check("t2_value_fall2", 16'(cap_value), 16'd5);
    check("t2_no_miss", 16'(miss_flag), 16'd0);
    cyc(17);

    // 3: saturation at 255 with 300 clk intervals, set beats clear
    prescale = 16'd0; edge_sel = 2'b01;
    rearm();
    rise_then(3);
    check("t3_arm_only", 16'(cap_valid), 16'd0);
    cyc(147); fall_then(150);
    rise_then(3);
    check("t3_value_sat", 16'(cap_value), 16'd255);
    check("t3_cap_ovf",   16'(cap_ovf),   16'd1);
    check("t3_ovf_flag",  16'(ovf_flag),  16'd1);
    cyc(147); fall_then(150);
    rise_then(2);
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    check("t3_set_beats_clr", 16'(ovf_flag), 16'd1);
    check("t3_cap_ovf2",      16'(cap_ovf),  16'd1);
    check("t3_valid2",        16'(cap_valid), 16'd1);
    cyc(1);
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    check("t3_clr_alone", 16'(ovf_flag), 16'd0);
    fall_then(5);

    // 4: consumer stalled, later edges dropped
    cap_ready = 1'b0;
    rearm();
    rise_then(5); fall_then(5);
    rise_then(3);
    check("t4_valid",  16'(cap_valid), 16'd1);
    check("t4_value",  16'(cap_value), 16'd10);
    check("t4_miss0",  16'(miss_flag), 16'd0);
    cyc(2); fall_then(7);
    rise_then(3);
    check("t4_held1",  16'(cap_value), 16'd10);
    check("t4_miss1",  16'(miss_flag), 16'd1);
    cyc(2); fall_then(9);
    rise_then(3);
    check("t4_held2",  16'(cap_value), 16'd10);
    check("t4_ovf_held", 16'(cap_ovf), 16'd0);
    cap_ready = 1'b1;
    cyc(1);
    check("t4_accepted", 16'(cap_valid), 16'd0);
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    check("t4_miss_clr", 16'(miss_flag), 16'd0);

    // 5: accept and new capture in the same cycle
    cap_ready = 1'b0;
    fall_then(5);
    rise_then(3);
    check("t5_first_value", 16'(cap_value), 16'd10);
    fall_then(3);
    rise_then(2);
    cap_ready = 1'b1;
    cyc(1);
    check("t5_valid_kept", 16'(cap_valid), 16'd1);
    check("t5_new_value",  16'(cap_value), 16'd6);
    check("t5_no_miss",    16'(miss_flag), 16'd0);
    cyc(1);
    check("t5_drained", 16'(cap_valid), 16'd0);

    // 6: reset mid-measure with pending word, then en toggle mid-interval
    cap_ready = 1'b0;
    fall_then(4);
    rise_then(3);
    check("t6_pending", 16'(cap_valid), 16'd1);
    check("t6_pend_value", 16'(cap_value), 16'd8);
    fall_then(4);
    rise_then(3);
    check("t6_miss_set", 16'(miss_flag), 16'd1);
    fall_then(3);
    rst = 1'b1;
    cyc(1);
    check("t6_rst_value", 16'(cap_value), 16'd0);
    check("t6_rst_valid", 16'(cap_valid), 16'd0);
    check("t6_rst_ovf",   16'(cap_ovf),   16'd0);
    check("t6_rst_miss",  16'(miss_flag), 16'd0);
    check("t6_rst_oflag", 16'(ovf_flag),  16'd0);
    rst = 1'b0;
    cap_ready = 1'b1;
    cyc(1);
    rise_then(3);
    check("t6_idle_arms", 16'(cap_valid), 16'd0);
    cyc(2); fall_then(5);
    rise_then(3);
    check("t6_post_rst_valid", 16'(cap_valid), 16'd1);
    check("t6_post_rst_value", 16'(cap_value), 16'd10);
    cyc(2); fall_then(2);
    en = 1'b0;
    cyc(2);
    en = 1'b1;
    cyc(1);
    rise_then(3);
    check("t6_reen_arm_only", 16'(cap_valid), 16'd0);
    cyc(2); fall_then(5);
    rise_then(3);
    check("t6_reen_valid", 16'(cap_valid), 16'd1);
    check("t6_reen_value", 16'(cap_value), 16'd10);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
